// File: rtl/avl_mem_bridge.sv
// avl_mem_bridge: CPU data-memory port to wide Avalon-MM SDRAM bridge.
// One transaction at a time. Byte/half/word accesses map onto one 32-bit
// lane of the Avalon line. Misaligned requests and read timeouts complete
// with an error.
//
// Handshake: an Avalon command (avl_read/avl_write) is presented with its
// address, data and byte enables and all of them are held unchanged until
// a clock edge that samples avl_waitrequest=0. That edge is the acceptance
// of the command. A CPU request is taken only in IDLE. Every accepted
// request finishes with a single-cycle mem_ready, and mem_err qualifies it.
module avl_mem_bridge #(
  parameter int RAM_ADDR_W = 26,
  parameter int RAM_DATA_W = 128,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    avl_waitrequest,
  input  logic                    avl_readdatavalid,
  input  logic [RAM_DATA_W-1:0]   avl_readdata,
  output logic [RAM_ADDR_W-1:0]   avl_address,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [RAM_DATA_W-1:0]   avl_writedata,
  output logic [RAM_DATA_W/8-1:0] avl_byteenable,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [1:0]              mem_size,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_ready,
  output logic                    mem_err,
  output logic                    mem_busy,
  output logic [2:0]              state_dbg
);

  localparam int LANES  = RAM_DATA_W / 32;
  localparam int LB     = $clog2(RAM_DATA_W / 8);
  localparam int BE_W   = RAM_DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state;
  logic [LANE_W-1:0] lane_q;
  logic [CNT_W-1:0]  cnt;

  logic              misaligned;
  logic [LANE_W-1:0] lane_calc;
  logic [3:0]        be_base;
  logic [BE_W-1:0]   be_calc;
  logic [RAM_DATA_W-1:0] wdata_calc;
  logic [DATA_W-1:0] rd_lane;

  assign state_dbg = state;

  // Selected 32-bit lane of the incoming read line.
  assign rd_lane = avl_readdata[{lane_q, 5'b00000} +: 32];

  // Decode the incoming CPU request: alignment, lane, byte enables, data.
  always_comb begin
    lane_calc  = LANE_W'((mem_addr >> 2) & ADDR_W'(LANES - 1));
    misaligned = 1'b0;
    be_base    = 4'b1111;
    wdata_calc = {LANES{mem_wdata}};
    case (mem_size)
      2'b00: begin
        be_base    = 4'b0001 << mem_addr[1:0];
        wdata_calc = {(4 * LANES){mem_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = mem_addr[0];
        be_base    = 4'b0011 << mem_addr[1:0];
        wdata_calc = {(2 * LANES){mem_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |mem_addr[1:0];
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
    be_calc = BE_W'(be_base) << {lane_calc, 2'b00};
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= IDLE;
      lane_q         <= '0;
      cnt            <= '0;
      avl_address    <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_writedata  <= '0;
      avl_byteenable <= '0;
      mem_rdata      <= '0;
      mem_ready      <= 1'b0;
      mem_err        <= 1'b0;
      mem_busy       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            lane_q   <= lane_calc;
            mem_busy <= 1'b1;
            if (misaligned) begin
              // Completes without touching the Avalon side.
              state     <= RESP;
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
            end else begin
              mem_err     <= 1'b0;
              avl_address <= RAM_ADDR_W'(mem_addr >> LB);
              if (mem_we) begin
                state          <= WR_REQ;
                avl_write      <= 1'b1;
                avl_writedata  <= wdata_calc;
                avl_byteenable <= be_calc;
              end else begin
                state          <= RD_REQ;
                avl_read       <= 1'b1;
                avl_byteenable <= '1;
              end
            end
          end
        end
        WR_REQ: begin
          if (!avl_waitrequest) begin
            avl_write <= 1'b0;
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= 1'b0;
          end
        end
        RD_REQ: begin
          if (!avl_waitrequest) begin
            avl_read <= 1'b0;
            if (avl_readdatavalid) begin
              // Zero-latency slave: data arrives with the acceptance.
              mem_rdata <= rd_lane;
              state     <= RESP;
              mem_ready <= 1'b1;
              mem_err   <= 1'b0;
            end else begin
              state <= RD_WAIT;
              cnt   <= '0;
            end
          end
        end
        RD_WAIT: begin
          if (avl_readdatavalid) begin
            mem_rdata <= rd_lane;
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= 1'b0;
          end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_rdata <= '0;
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // mem_ready was raised on entry; drop everything back to idle.
          state    <= IDLE;
          mem_err  <= 1'b0;
          mem_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          avl_read  <= 1'b0;
          avl_write <= 1'b0;
          mem_err   <= 1'b0;
          mem_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avl_mem_bridge.sv
// Directed bench for avl_mem_bridge with a short read timeout.
module tb_avl_mem_bridge;

  localparam int TO = 8;

  logic          iCLK;
  logic          iRST;
  logic          avl_waitrequest;
  logic          avl_readdatavalid;
  logic [127:0]  avl_readdata;
  logic [25:0]   avl_address;
  logic          avl_read;
  logic          avl_write;
  logic [127:0]  avl_writedata;
  logic [15:0]   avl_byteenable;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          mem_err;
  logic          mem_busy;
  logic [2:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int wr_beats = 0;
  int rd_beats = 0;
  int ready_cnt = 0;
  int both_cnt = 0;

  logic [31:0] exp_q[$];

  localparam logic [127:0] LINE = 128'h44444444_33333333_22222222_11111111;

  avl_mem_bridge #(.TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .avl_waitrequest(avl_waitrequest), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .avl_address(avl_address),
    .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err), .mem_busy(mem_busy),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got running want finished");
    $fatal(1);
  end

  // Bus monitor: accepted beats, ready pulses, illegal overlap.
  always @(posedge iCLK) begin
    if (avl_write && !avl_waitrequest) wr_beats++;
    if (avl_read && !avl_waitrequest) rd_beats++;
    if (mem_ready) ready_cnt++;
    if (avl_read && avl_write) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic start(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_size  = size;
    mem_addr  = addr;
    mem_wdata = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " avl_read"}, 128'(avl_read), 128'd0);
    check_eq({tag, " avl_write"}, 128'(avl_write), 128'd0);
    check_eq({tag, " avl_address"}, 128'(avl_address), 128'd0);
    check_eq({tag, " avl_writedata"}, avl_writedata, 128'd0);
    check_eq({tag, " avl_byteenable"}, 128'(avl_byteenable), 128'd0);
    check_eq({tag, " mem_rdata"}, 128'(mem_rdata), 128'd0);
    check_eq({tag, " mem_ready"}, 128'(mem_ready), 128'd0);
    check_eq({tag, " mem_err"}, 128'(mem_err), 128'd0);
    check_eq({tag, " mem_busy"}, 128'(mem_busy), 128'd0);
    check_eq({tag, " state"}, 128'(state_dbg), 128'd0);
  endtask

  // Write: command appears after the sampling edge, held through stalls,
  // ready follows the accepting edge.
  task automatic do_write(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int stalls, input logic [25:0] exp_addr,
                          input logic [15:0] exp_be, input logic [127:0] exp_wd);
    int w0;
    w0 = wr_beats;
    start(1'b1, size, addr, wd);
    tick();
    mem_req = 1'b0;
    check_eq({tag, " write"}, 128'(avl_write), 128'd1);
    check_eq({tag, " read"}, 128'(avl_read), 128'd0);
    check_eq({tag, " addr"}, 128'(avl_address), 128'(exp_addr));
    check_eq({tag, " be"}, 128'(avl_byteenable), 128'(exp_be));
    check_eq({tag, " wdata"}, avl_writedata, exp_wd);
    check_eq({tag, " busy"}, 128'(mem_busy), 128'd1);
    avl_waitrequest = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      tick();
      check_eq({tag, " stall write"}, 128'(avl_write), 128'd1);
      check_eq({tag, " stall addr"}, 128'(avl_address), 128'(exp_addr));
      check_eq({tag, " stall be"}, 128'(avl_byteenable), 128'(exp_be));
      check_eq({tag, " stall wdata"}, avl_writedata, exp_wd);
      check_eq({tag, " stall ready"}, 128'(mem_ready), 128'd0);
    end
    avl_waitrequest = 1'b0;
    tick();
    check_eq({tag, " ready"}, 128'(mem_ready), 128'd1);
    check_eq({tag, " err"}, 128'(mem_err), 128'd0);
    check_eq({tag, " write dropped"}, 128'(avl_write), 128'd0);
    tick();
    check_eq({tag, " ready pulse"}, 128'(mem_ready), 128'd0);
    check_eq({tag, " idle busy"}, 128'(mem_busy), 128'd0);
    check_eq({tag, " beats"}, 128'(wr_beats - w0), 128'd1);
  endtask

  // Read: respond=0 models a slave that never returns data (timeout).
  // delay counts cycles from the accepting edge to the edge seeing valid.
  task automatic do_read(input string tag, input logic [31:0] addr, input int stalls,
                         input int delay, input logic respond, input logic [127:0] line,
                         input logic exp_err);
    int n;
    logic [31:0] exp_rd;
    start(1'b0, 2'b10, addr, 32'h0);
    tick();
    mem_req = 1'b0;
    check_eq({tag, " read"}, 128'(avl_read), 128'd1);
    check_eq({tag, " write"}, 128'(avl_write), 128'd0);
    check_eq({tag, " be"}, 128'(avl_byteenable), 128'hFFFF);
    check_eq({tag, " addr"}, 128'(avl_address), 128'(addr >> 4));
    avl_waitrequest = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      tick();
      check_eq({tag, " stall read"}, 128'(avl_read), 128'd1);
    end
    avl_waitrequest = 1'b0;
    if (respond && delay == 0) begin
      avl_readdatavalid = 1'b1;
      avl_readdata      = line;
    end
    tick();
    avl_readdatavalid = 1'b0;
    check_eq({tag, " read dropped"}, 128'(avl_read), 128'd0);
    if (!(respond && delay == 0)) begin
      n = 0;
      while (!mem_ready && n < 40) begin
        if (respond && n == delay - 1) begin
          avl_readdatavalid = 1'b1;
          avl_readdata      = line;
        end
        tick();
        avl_readdatavalid = 1'b0;
        n++;
      end
      check_eq({tag, " latency"}, 128'(n), respond ? 128'(delay) : 128'(TO));
    end
    exp_rd = exp_q.pop_front();
    check_eq({tag, " ready"}, 128'(mem_ready), 128'd1);
    check_eq({tag, " err"}, 128'(mem_err), 128'(exp_err));
    check_eq({tag, " rdata"}, 128'(mem_rdata), 128'(exp_rd));
    tick();
    check_eq({tag, " ready pulse"}, 128'(mem_ready), 128'd0);
    check_eq({tag, " idle busy"}, 128'(mem_busy), 128'd0);
    check_eq({tag, " rdata hold"}, 128'(mem_rdata), 128'(exp_rd));
  endtask

  // Stimulus
  initial begin
    int r0, w0, rb0;
    logic [1:0]  mis_size [3];
    logic [31:0] mis_addr [3];
    logic        mis_we   [3];

    iRST = 1'b1;
    avl_waitrequest = 1'b0;
    avl_readdatavalid = 1'b0;
    avl_readdata = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_size = 2'b00;
    mem_addr = '0;
    mem_wdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    iRST = 1'b0;
    tick();

    // Word write: lane 1, bytes 7:4.
    do_write("wr_word", 2'b10, 32'h0000_0014, 32'hDEADBEEF, 0, 26'd1, 16'h00F0,
             {4{32'hDEADBEEF}});
    // Half write at 0x06: lane 1, byte offset 2 -> bits 6,7.
    do_write("wr_half", 2'b01, 32'h0000_0006, 32'h0000_1234, 0, 26'd0, 16'h00C0,
             {8{16'h1234}});
    // Byte write at 0x23 under 3 stall cycles: lane 0, offset 3.
    do_write("wr_byte", 2'b00, 32'h0000_0023, 32'h0000_00A5, 3, 26'd2, 16'h0008,
             {16{8'hA5}});

    // Read at 0x38: addr[3:2]=2 selects bits 95:64 of the line.
    exp_q.push_back(32'h33333333);
    do_read("rd_lane2", 32'h0000_0038, 0, 6, 1'b1, LINE, 1'b0);
    // Read at 0x3C with data in the acceptance cycle, after 2 stalls.
    exp_q.push_back(32'h44444444);
    do_read("rd_lane3_zero", 32'h0000_003C, 2, 0, 1'b1, LINE, 1'b0);

    // Misaligned requests complete at once with error and no bus traffic.
    mis_size = '{2'b01, 2'b10, 2'b11};
    mis_addr = '{32'h1, 32'h2, 32'h0};
    mis_we   = '{1'b0, 1'b1, 1'b0};
    w0 = wr_beats;
    rb0 = rd_beats;
    for (int i = 0; i < 3; i++) begin
      start(mis_we[i], mis_size[i], mis_addr[i], 32'hFFFF_FFFF);
      tick();
      mem_req = 1'b0;
      check_eq($sformatf("mis%0d ready", i), 128'(mem_ready), 128'd1);
      check_eq($sformatf("mis%0d err", i), 128'(mem_err), 128'd1);
      check_eq($sformatf("mis%0d read", i), 128'(avl_read), 128'd0);
      check_eq($sformatf("mis%0d write", i), 128'(avl_write), 128'd0);
      tick();
      check_eq($sformatf("mis%0d ready pulse", i), 128'(mem_ready), 128'd0);
      check_eq($sformatf("mis%0d err clear", i), 128'(mem_err), 128'd0);
      check_eq($sformatf("mis%0d busy", i), 128'(mem_busy), 128'd0);
    end
    check_eq("mis wr beats", 128'(wr_beats - w0), 128'd0);
    check_eq("mis rd beats", 128'(rd_beats - rb0), 128'd0);

    // Timeout: slave never answers.
    exp_q.push_back(32'h0);
    do_read("rd_timeout", 32'h0000_0020, 0, 0, 1'b0, LINE, 1'b1);
    // Late data after the timeout is dropped.
    r0 = ready_cnt;
    avl_readdatavalid = 1'b1;
    avl_readdata = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
    tick();
    tick();
    avl_readdatavalid = 1'b0;
    tick();
    check_eq("late rdata", 128'(mem_rdata), 128'd0);
    check_eq("late ready", 128'(ready_cnt - r0), 128'd0);
    check_eq("late state", 128'(state_dbg), 128'd0);
    // Next read after the timeout behaves normally: 0x24 -> lane 1.
    exp_q.push_back(32'h22222222);
    do_read("rd_after_to", 32'h0000_0024, 0, 2, 1'b1, LINE, 1'b0);

    // Reset while waiting for read data.
    start(1'b0, 2'b10, 32'h0000_0010, 32'h0);
    tick();
    mem_req = 1'b0;
    tick();
    tick();
    check_eq("rst pre state", 128'(state_dbg), 128'd3);
    r0 = ready_cnt;
    iRST = 1'b1;
    tick();
    check_all_zero("rst mid");
    iRST = 1'b0;
    repeat (3) tick();
    check_eq("rst no ready", 128'(ready_cnt - r0), 128'd0);
    check_eq("rst busy", 128'(mem_busy), 128'd0);

    // mem_req held high: one transaction per IDLE sample (every 3 cycles).
    r0 = ready_cnt;
    w0 = wr_beats;
    start(1'b1, 2'b10, 32'h0000_0000, 32'h11223344);
    tick();
    check_eq("hold busy", 128'(mem_busy), 128'd1);
    repeat (5) tick();
    mem_req = 1'b0;
    repeat (4) tick();
    check_eq("hold ready count", 128'(ready_cnt - r0), 128'd2);
    check_eq("hold write beats", 128'(wr_beats - w0), 128'd2);
    check_eq("hold idle", 128'(mem_busy), 128'd0);

    check_eq("read/write overlap", 128'(both_cnt), 128'd0);
    check_eq("exp_q drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
